// File: rtl/hid_pkg.sv
// rtl/hid_pkg.sv - shared command codes, frame lengths, FSM encoding and helpers for the HID master
package hid_pkg;

    localparam logic [7:0] HID_CMD_STATUS = 8'h00;
    localparam logic [7:0] HID_CMD_KBD    = 8'h01;
    localparam logic [7:0] HID_CMD_MOUSE  = 8'h02;
    localparam logic [7:0] HID_CMD_JOY    = 8'h03;
    localparam logic [7:0] HID_CMD_DB9    = 8'h04;

    localparam logic [2:0] HID_LEN_STATUS = 3'd2;
    localparam logic [2:0] HID_LEN_KBD    = 3'd1;
    localparam logic [2:0] HID_LEN_MOUSE  = 3'd3;
    localparam logic [2:0] HID_LEN_JOY    = 3'd5;
    localparam logic [2:0] HID_LEN_DB9    = 3'd1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_GAPW = 2'd2,
        ST_PAY  = 2'd3
    } hid_state_t;

    function automatic logic [2:0] frame_len(input logic [7:0] cmd);
        case (cmd)
            HID_CMD_KBD:   return HID_LEN_KBD;
            HID_CMD_MOUSE: return HID_LEN_MOUSE;
            HID_CMD_JOY:   return HID_LEN_JOY;
            HID_CMD_DB9:   return HID_LEN_DB9;
            default:       return HID_LEN_STATUS;
        endcase
    endfunction

    // Signed 8-bit add clamped to -128..+127
    function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] s;
        s = {a[7], a} + {b[7], b};
        if (s[8] != s[7]) return s[8] ? 8'h80 : 8'h7F;
        return s[7:0];
    endfunction

endpackage

// File: rtl/hid_kbd_fifo.sv
// rtl/hid_kbd_fifo.sv - keyboard code FIFO; a pop in the same cycle frees a slot for a push when full
module hid_kbd_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_push,
    input  logic [7:0] i_data,
    input  logic       i_pop,
    output logic [7:0] o_data,
    output logic       o_full,
    output logic       o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [AW:0]   r_count;
    logic          w_do_pop;
    logic          w_do_push;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign o_data    = r_mem[r_rd];
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);

    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wr] <= i_data;
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wr <= r_wr + 1'b1;
            if (w_do_pop)  r_rd <= r_rd + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/hid_mcu_master.sv
// rtl/hid_mcu_master.sv - HID protocol initiator: arbitrates input sources and emits strobed command frames
module hid_mcu_master
    import hid_pkg::*;
#(
    parameter int GAP       = 2,
    parameter int KBD_DEPTH = 4
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_kbd_valid,
    input  logic [7:0] i_kbd_code,
    output logic       o_kbd_ready,
    input  logic       i_mouse_valid,
    input  logic [1:0] i_mouse_btns,
    input  logic [7:0] i_mouse_dx,
    input  logic [7:0] i_mouse_dy,
    input  logic       i_joy_valid,
    input  logic [7:0] i_joy_dev,
    input  logic [7:0] i_joy_dig,
    input  logic [7:0] i_joy_ax,
    input  logic [7:0] i_joy_ay,
    input  logic [7:0] i_joy_extra,
    output logic       o_joy_ready,
    input  logic       i_status_req,
    output logic       o_status_valid,
    output logic [7:0] o_status_b0,
    output logic [7:0] o_status_b1,
    input  logic       i_irq,
    output logic       o_iack,
    output logic [5:0] o_db9_state,
    output logic       o_db9_valid,
    output logic       o_hid_strobe,
    output logic       o_hid_start,
    output logic [7:0] o_hid_dout,
    input  logic [7:0] i_hid_din
);
    hid_state_t r_state, w_next;
    logic [7:0] r_cmd;
    logic [2:0] r_len, r_n;
    logic [3:0] r_gap;
    logic       r_after_pay;
    logic [7:0] r_pay [8];
    logic [7:0] r_mx, r_my;
    logic [1:0] r_mbtn;
    logic       r_mpend;
    logic [7:0] r_jdev, r_jdig, r_jax, r_jay, r_jext;
    logic       r_jpend, r_spend;
    logic [7:0] r_status_b0, r_status_b1;
    logic       r_status_valid, r_db9_valid;
    logic [5:0] r_db9_state;
    logic [7:0] w_sel_cmd, w_fifo_head;
    logic       w_fifo_full, w_fifo_empty, w_req_any, w_in_cmd, w_gap_done, w_frame_end;

    assign w_in_cmd    = (r_state == ST_CMD);
    assign w_gap_done  = (r_state == ST_GAPW) && (r_gap == 4'(GAP - 1));
    assign w_frame_end = w_gap_done && (r_n == r_len);
    assign w_req_any   = i_irq | ~w_fifo_empty | r_jpend | r_mpend | r_spend;

    always_comb begin
        w_sel_cmd = HID_CMD_STATUS;
        if (i_irq)              w_sel_cmd = HID_CMD_DB9;
        else if (!w_fifo_empty) w_sel_cmd = HID_CMD_KBD;
        else if (r_jpend)       w_sel_cmd = HID_CMD_JOY;
        else if (r_mpend)       w_sel_cmd = HID_CMD_MOUSE;
    end

    hid_kbd_fifo #(.DEPTH(KBD_DEPTH)) u_kbd_fifo (
        .i_clk    (i_clk),
        .i_reset_n(i_reset_n),
        .i_push   (i_kbd_valid),
        .i_data   (i_kbd_code),
        .i_pop    (w_in_cmd && (r_cmd == HID_CMD_KBD)),
        .o_data   (w_fifo_head),
        .o_full   (w_fifo_full),
        .o_empty  (w_fifo_empty)
    );

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) r_state <= ST_IDLE;
        else            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_req_any) w_next = ST_CMD;
            ST_CMD:  w_next = ST_GAPW;
            ST_GAPW: if (w_gap_done) w_next = (r_n == r_len) ? ST_IDLE : ST_PAY;
            ST_PAY:  w_next = ST_GAPW;
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        o_hid_strobe = (r_state == ST_CMD) || (r_state == ST_PAY);
        o_hid_start  = (r_state == ST_CMD);
        o_iack       = w_in_cmd && (r_cmd == HID_CMD_DB9);
        o_hid_dout   = 8'h00;
        if (r_state == ST_CMD)      o_hid_dout = r_cmd;
        else if (r_state == ST_PAY) o_hid_dout = r_pay[r_n];
    end

    // Frame sequencing and payload snapshot taken in the CMD cycle
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_cmd <= 8'h00; r_len <= '0; r_n <= '0; r_gap <= '0; r_after_pay <= 1'b0;
            for (int i = 0; i < 8; i++) r_pay[i] <= 8'h00;
        end else begin
            if (r_state == ST_IDLE) begin
                r_cmd <= w_sel_cmd;
                r_len <= frame_len(w_sel_cmd);
                r_n   <= '0;
            end
            if (w_in_cmd) begin
                case (r_cmd)
                    HID_CMD_KBD:   r_pay[0] <= w_fifo_head;
                    HID_CMD_MOUSE: begin
                        r_pay[0] <= {6'd0, r_mbtn}; r_pay[1] <= r_mx; r_pay[2] <= r_my;
                    end
                    HID_CMD_JOY:   begin
                        r_pay[0] <= r_jdev; r_pay[1] <= r_jdig; r_pay[2] <= r_jax;
                        r_pay[3] <= r_jay;  r_pay[4] <= r_jext;
                    end
                    default: begin r_pay[0] <= 8'h00; r_pay[1] <= 8'h00; end
                endcase
            end
            r_gap       <= (r_state == ST_GAPW) ? r_gap + 1'b1 : 4'd0;
            r_after_pay <= (r_state == ST_PAY);
            if (r_state == ST_PAY) r_n <= r_n + 1'b1;
        end
    end

    // Responder data_out settles on the strobe edge, so sample it one cycle into GAPW
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_status_b0 <= 8'h00; r_status_b1 <= 8'h00; r_db9_state <= 6'd0;
            r_status_valid <= 1'b0; r_db9_valid <= 1'b0;
        end else begin
            r_status_valid <= w_frame_end && (r_cmd == HID_CMD_STATUS);
            r_db9_valid    <= w_frame_end && (r_cmd == HID_CMD_DB9);
            if ((r_state == ST_GAPW) && r_after_pay) begin
                if (r_cmd == HID_CMD_DB9) r_db9_state <= i_hid_din[5:0];
                if (r_cmd == HID_CMD_STATUS && r_n == 3'd1) r_status_b0 <= i_hid_din;
                if (r_cmd == HID_CMD_STATUS && r_n == 3'd2) r_status_b1 <= i_hid_din;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_mx <= 8'h00; r_my <= 8'h00; r_mbtn <= 2'b00; r_mpend <= 1'b0;
            r_jdev <= 8'h00; r_jdig <= 8'h00; r_jax <= 8'h00; r_jay <= 8'h00; r_jext <= 8'h00;
            r_jpend <= 1'b0; r_spend <= 1'b0;
        end else begin
            if (w_in_cmd && r_cmd == HID_CMD_MOUSE) begin
                r_mx    <= i_mouse_valid ? i_mouse_dx : 8'h00;
                r_my    <= i_mouse_valid ? i_mouse_dy : 8'h00;
                r_mpend <= i_mouse_valid;
                if (i_mouse_valid) r_mbtn <= i_mouse_btns;
            end else if (i_mouse_valid) begin
                r_mx    <= sat_add8(r_mx, i_mouse_dx);
                r_my    <= sat_add8(r_my, i_mouse_dy);
                r_mbtn  <= i_mouse_btns;
                r_mpend <= 1'b1;
            end
            if (w_in_cmd && r_cmd == HID_CMD_JOY) begin
                r_jpend <= 1'b0;
            end else if (i_joy_valid && !r_jpend) begin
                r_jdev <= i_joy_dev; r_jdig <= i_joy_dig; r_jax <= i_joy_ax;
                r_jay  <= i_joy_ay;  r_jext <= i_joy_extra; r_jpend <= 1'b1;
            end
            if (w_in_cmd && r_cmd == HID_CMD_STATUS) r_spend <= 1'b0;
            else if (i_status_req)                   r_spend <= 1'b1;
        end
    end

    assign o_kbd_ready    = ~w_fifo_full;
    assign o_joy_ready    = ~r_jpend;
    assign o_status_valid = r_status_valid;
    assign o_status_b0    = r_status_b0;
    assign o_status_b1    = r_status_b1;
    assign o_db9_state    = r_db9_state;
    assign o_db9_valid    = r_db9_valid;

endmodule

// File: tb/tb_hid_mcu_master.sv
// tb/tb_hid_mcu_master.sv - directed self-checking bench for hid_mcu_master
module tb_hid_mcu_master;
    localparam int GAP = 2;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       kbd_valid = 1'b0, mouse_valid = 1'b0, joy_valid = 1'b0, status_req = 1'b0, irq = 1'b0;
    logic [7:0] kbd_code = 8'h00, mouse_dx = 8'h00, mouse_dy = 8'h00;
    logic [1:0] mouse_btns = 2'b00;
    logic [7:0] joy_dev = 8'h00, joy_dig = 8'h00, joy_ax = 8'h00, joy_ay = 8'h00, joy_extra = 8'h00;
    logic [7:0] hid_din = 8'h00;
    logic       kbd_ready, joy_ready, status_valid, iack, db9_valid, hid_strobe, hid_start;
    logic [7:0] status_b0, status_b1, hid_dout;
    logic [5:0] db9_state;

    int errors = 0;
    int checks = 0;

    logic [8:0] q[$];
    int         qt[$];
    int         cyc = 0;
    int         n_status_v = 0, n_db9_v = 0, n_iack = 0;
    logic [7:0] resp_cmd = 8'h00;
    int         resp_idx = 0;

    hid_mcu_master #(.GAP(GAP), .KBD_DEPTH(4)) dut (
        .i_clk(clk), .i_reset_n(reset_n),
        .i_kbd_valid(kbd_valid), .i_kbd_code(kbd_code), .o_kbd_ready(kbd_ready),
        .i_mouse_valid(mouse_valid), .i_mouse_btns(mouse_btns), .i_mouse_dx(mouse_dx), .i_mouse_dy(mouse_dy),
        .i_joy_valid(joy_valid), .i_joy_dev(joy_dev), .i_joy_dig(joy_dig), .i_joy_ax(joy_ax),
        .i_joy_ay(joy_ay), .i_joy_extra(joy_extra), .o_joy_ready(joy_ready),
        .i_status_req(status_req), .o_status_valid(status_valid), .o_status_b0(status_b0),
        .o_status_b1(status_b1), .i_irq(irq), .o_iack(iack), .o_db9_state(db9_state),
        .o_db9_valid(db9_valid), .o_hid_strobe(hid_strobe), .o_hid_start(hid_start),
        .o_hid_dout(hid_dout), .i_hid_din(hid_din)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        cyc++;
        if (hid_strobe) begin
            q.push_back({hid_start, hid_dout});
            qt.push_back(cyc);
        end
        if (status_valid) n_status_v++;
        if (db9_valid)    n_db9_v++;
        if (iack)         n_iack++;
    end

    // Responder model: CMD0 returns 0x01 then 0x00, CMD4 returns the db9 value
    always @(posedge clk) begin
        if (hid_strobe) begin
            if (hid_start) begin
                resp_cmd <= hid_dout;
                resp_idx <= 0;
            end else begin
                if (resp_cmd == 8'h00)      hid_din <= (resp_idx == 0) ? 8'h01 : 8'h00;
                else if (resp_cmd == 8'h04) hid_din <= 8'h2A;
                resp_idx <= resp_idx + 1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) tick();
        checks++; if (hid_strobe !== 1'b0) begin errors++; $display("FAIL reset_strobe: got %b expected 0", hid_strobe); end
        checks++; if (hid_start !== 1'b0) begin errors++; $display("FAIL reset_start: got %b expected 0", hid_start); end
        checks++; if (hid_dout !== 8'h00) begin errors++; $display("FAIL reset_dout: got %h expected 00", hid_dout); end
        checks++; if (kbd_ready !== 1'b1) begin errors++; $display("FAIL reset_kbd_ready: got %b expected 1", kbd_ready); end
        checks++; if (joy_ready !== 1'b1) begin errors++; $display("FAIL reset_joy_ready: got %b expected 1", joy_ready); end
        checks++; if ({iack, status_valid, db9_valid} !== 3'b000) begin errors++; $display("FAIL reset_pulses: got %b expected 000", {iack, status_valid, db9_valid}); end
        checks++; if ({status_b0, status_b1, 2'b00, db9_state} !== 24'h0) begin errors++; $display("FAIL reset_data: got %h expected 000000", {status_b0, status_b1, 2'b00, db9_state}); end
        reset_n = 1'b1;
        repeat (3) tick();
    endtask

    task automatic test_kbd();
        logic [8:0] exp[4] = '{9'h101, 9'h03A, 9'h101, 9'h0BA};
        q.delete(); qt.delete();
        kbd_valid = 1'b1; kbd_code = 8'h3A;
        tick();
        kbd_code = 8'hBA;
        tick();
        kbd_valid = 1'b0;
        repeat (25) tick();
        checks++; if (q.size() != 4) begin errors++; $display("FAIL kbd_frame_len: got %0d expected 4", q.size()); end
        for (int i = 0; i < 4 && i < q.size(); i++) begin
            checks++; if (q[i] !== exp[i]) begin errors++; $display("FAIL kbd_byte%0d: got %h expected %h", i, q[i], exp[i]); end
        end
        if (qt.size() == 4) begin
            checks++; if (qt[1] - qt[0] != GAP + 1) begin errors++; $display("FAIL kbd_spacing: got %0d expected %0d", qt[1] - qt[0], GAP + 1); end
            checks++; if (qt[3] - qt[2] != GAP + 1) begin errors++; $display("FAIL kbd_spacing2: got %0d expected %0d", qt[3] - qt[2], GAP + 1); end
        end
    endtask

    task automatic test_mouse_sat();
        logic [8:0] exp1[4] = '{9'h102, 9'h001, 9'h07F, 9'h00A};
        logic [8:0] exp2[8] = '{9'h102, 9'h002, 9'h080, 9'h0FA, 9'h102, 9'h003, 9'h09C, 9'h0FD};
        q.delete();
        mouse_valid = 1'b1; mouse_btns = 2'd1; mouse_dx = 8'd100; mouse_dy = 8'd5;
        repeat (2) tick();
        mouse_valid = 1'b0;
        repeat (20) tick();
        checks++; if (q.size() != 4) begin errors++; $display("FAIL mouse_pos_len: got %0d expected 4", q.size()); end
        for (int i = 0; i < 4 && i < q.size(); i++) begin
            checks++; if (q[i] !== exp1[i]) begin errors++; $display("FAIL mouse_pos_byte%0d: got %h expected %h", i, q[i], exp1[i]); end
        end
        // Third delta lands in the snapshot cycle and must carry into a second frame
        q.delete();
        mouse_valid = 1'b1; mouse_btns = 2'd2; mouse_dx = 8'h9C; mouse_dy = 8'hFD;
        repeat (2) tick();
        mouse_btns = 2'd3;
        tick();
        mouse_valid = 1'b0;
        repeat (35) tick();
        checks++; if (q.size() != 8) begin errors++; $display("FAIL mouse_neg_len: got %0d expected 8", q.size()); end
        for (int i = 0; i < 8 && i < q.size(); i++) begin
            checks++; if (q[i] !== exp2[i]) begin errors++; $display("FAIL mouse_neg_byte%0d: got %h expected %h", i, q[i], exp2[i]); end
        end
    endtask

    task automatic test_irq_priority();
        logic [8:0] exp[4] = '{9'h104, 9'h000, 9'h101, 9'h055};
        bit found = 0;
        q.delete(); n_db9_v = 0; n_iack = 0;
        irq = 1'b1; kbd_valid = 1'b1; kbd_code = 8'h55;
        tick();
        kbd_valid = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            if (iack) begin
                found = 1;
                checks++; if ({hid_start, hid_dout} !== 9'h104) begin errors++; $display("FAIL iack_with_start: got %h expected 104", {hid_start, hid_dout}); end
            end else tick();
        end
        checks++; if (!found) begin errors++; $display("FAIL iack_timeout: got 0 expected 1"); end
        irq = 1'b0;
        repeat (25) tick();
        checks++; if (q.size() != 4) begin errors++; $display("FAIL irq_frame_len: got %0d expected 4", q.size()); end
        for (int i = 0; i < 4 && i < q.size(); i++) begin
            checks++; if (q[i] !== exp[i]) begin errors++; $display("FAIL irq_byte%0d: got %h expected %h", i, q[i], exp[i]); end
        end
        checks++; if (db9_state !== 6'h2A) begin errors++; $display("FAIL db9_state: got %h expected 2a", db9_state); end
        checks++; if (n_db9_v != 1) begin errors++; $display("FAIL db9_valid_count: got %0d expected 1", n_db9_v); end
        checks++; if (n_iack != 1) begin errors++; $display("FAIL iack_count: got %0d expected 1", n_iack); end
    endtask

    task automatic test_status();
        logic [8:0] exp[3] = '{9'h100, 9'h000, 9'h000};
        q.delete(); n_status_v = 0;
        status_req = 1'b1;
        repeat (2) tick();
        status_req = 1'b0;
        repeat (20) tick();
        checks++; if (q.size() != 3) begin errors++; $display("FAIL status_frame_len: got %0d expected 3", q.size()); end
        for (int i = 0; i < 3 && i < q.size(); i++) begin
            checks++; if (q[i] !== exp[i]) begin errors++; $display("FAIL status_byte%0d: got %h expected %h", i, q[i], exp[i]); end
        end
        checks++; if (status_b0 !== 8'h01) begin errors++; $display("FAIL status_b0: got %h expected 01", status_b0); end
        checks++; if (status_b1 !== 8'h00) begin errors++; $display("FAIL status_b1: got %h expected 00", status_b1); end
        checks++; if (n_status_v != 1) begin errors++; $display("FAIL status_valid_count: got %0d expected 1", n_status_v); end
    endtask

    task automatic test_joy();
        logic [8:0] exp[6] = '{9'h103, 9'h001, 9'h010, 9'h080, 9'h07F, 9'h003};
        q.delete();
        checks++; if (joy_ready !== 1'b1) begin errors++; $display("FAIL joy_ready_idle: got %b expected 1", joy_ready); end
        joy_valid = 1'b1; joy_dev = 8'h01; joy_dig = 8'h10; joy_ax = 8'h80; joy_ay = 8'h7F; joy_extra = 8'h03;
        tick();
        joy_dev = 8'h00; joy_dig = 8'hEE; joy_ax = 8'h11; joy_ay = 8'h22; joy_extra = 8'h33;
        checks++; if (joy_ready !== 1'b0) begin errors++; $display("FAIL joy_ready_pending: got %b expected 0", joy_ready); end
        tick();
        joy_valid = 1'b0;
        checks++; if ({joy_ready, hid_start} !== 2'b01) begin errors++; $display("FAIL joy_ready_at_cmd: got %b expected 01", {joy_ready, hid_start}); end
        tick();
        checks++; if (joy_ready !== 1'b1) begin errors++; $display("FAIL joy_ready_after_cmd: got %b expected 1", joy_ready); end
        repeat (25) tick();
        checks++; if (q.size() != 6) begin errors++; $display("FAIL joy_frame_len: got %0d expected 6", q.size()); end
        for (int i = 0; i < 6 && i < q.size(); i++) begin
            checks++; if (q[i] !== exp[i]) begin errors++; $display("FAIL joy_byte%0d: got %h expected %h", i, q[i], exp[i]); end
        end
    endtask

    task automatic test_reset_mid_frame();
        bit found = 0;
        joy_valid = 1'b1; joy_dev = 8'h01; joy_dig = 8'h10; joy_ax = 8'h80; joy_ay = 8'h7F; joy_extra = 8'h03;
        tick();
        joy_valid = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            if (hid_start && hid_dout == 8'h03) found = 1; else tick();
        end
        checks++; if (!found) begin errors++; $display("FAIL rst_cmd3_timeout: got 0 expected 1"); end
        kbd_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            kbd_code = 8'h21 + 8'(i);
            tick();
        end
        kbd_valid = 1'b0;
        checks++; if (kbd_ready !== 1'b0) begin errors++; $display("FAIL fifo_full_ready: got %b expected 0", kbd_ready); end
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            if (hid_strobe && !hid_start) found = 1; else tick();
        end
        checks++; if (!found) begin errors++; $display("FAIL rst_payload_timeout: got 0 expected 1"); end
        reset_n = 1'b0;
        tick();
        checks++; if ({hid_strobe, hid_start} !== 2'b00) begin errors++; $display("FAIL rst_strobe_drop: got %b expected 00", {hid_strobe, hid_start}); end
        checks++; if ({kbd_ready, joy_ready} !== 2'b11) begin errors++; $display("FAIL rst_ready: got %b expected 11", {kbd_ready, joy_ready}); end
        reset_n = 1'b1;
        q.delete();
        repeat (20) tick();
        checks++; if (q.size() != 0) begin errors++; $display("FAIL rst_fifo_flushed: got %0d bytes expected 0", q.size()); end
        kbd_valid = 1'b1; kbd_code = 8'h11;
        tick();
        kbd_valid = 1'b0;
        repeat (15) tick();
        checks++; if (q.size() != 2) begin errors++; $display("FAIL rst_clean_len: got %0d expected 2", q.size()); end
        if (q.size() == 2) begin
            checks++; if (q[0] !== 9'h101) begin errors++; $display("FAIL rst_clean_cmd: got %h expected 101", q[0]); end
            checks++; if (q[1] !== 9'h011) begin errors++; $display("FAIL rst_clean_pay: got %h expected 011", q[1]); end
        end
    endtask

    initial begin
        test_reset();
        test_kbd();
        test_mouse_sat();
        test_irq_priority();
        test_status();
        test_joy();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
